dn_sequencer: RTL
=================

# dn_sequencer

Download and reset sequencer between the MiSTer ioctl stream and the system's writable memories. It routes ioctl download bytes to one of several target RAMs by ioctl_index and zero-fills work RAM after reset and after each download. It holds the system in reset until memory contents are valid, then hands the work-RAM write port to the CPU. It sits between the emu top level and system, and replaces direct dn_wr/dn_index fan-out.

## Interface
Parameters:
- ADDR_W, 17: memory address width; ioctl_addr[ADDR_W-1:0] is used.
- TARGETS, 6: number of target memories; mem_we width.
- WRAM_TGT, 5: target index of work RAM (CPU-writable, cleared).
- CLEAR_AW, 12: work-RAM clear span is 2^CLEAR_AW bytes.
- HOLD_CYCLES, 16: extra sys_reset cycles after a clear completes.

Ports (one clock; reset is synchronous, active-high):
- clk_sys  in  1  system clock, sole clock.
- reset  in  1  synchronous active-high reset.
- ioctl_download  in  1  download active.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  target select.
- ioctl_wait  out  1  download backpressure.
- cpu_wr  in  1  CPU work-RAM write request, one-cycle pulse.
- cpu_addr  in  ADDR_W  CPU write address.
- cpu_dout  in  8  CPU write data.
- cpu_ack  out  1  CPU write accepted (pulse).
- mem_addr  out  ADDR_W  shared write address.
- mem_din  out  8  shared write data.
- mem_we  out  TARGETS  one-hot write enable.
- sys_reset  out  1  reset to system core.
- dn_err  out  1  sticky: a download byte was dropped.

## Operation
- States: CLEAR, HOLD, RUN, LOAD. Reset enters CLEAR with clear counter 0 and hold counter 0.
- CLEAR: one write per cycle: mem_we[WRAM_TGT]=1, mem_din=0, mem_addr = counter. After address 2^CLEAR_AW-1, go to HOLD. ioctl_wait=1 throughout.
- HOLD: count HOLD_CYCLES cycles, then go to RUN. ioctl_download=1 during HOLD goes to LOAD.
- RUN: sys_reset=0. cpu_wr registers a write to WRAM_TGT on the next cycle and pulses cpu_ack in that same cycle. ioctl_download=1 goes to LOAD; a cpu_wr in that same cycle is dropped with no ack.
- LOAD: each ioctl_wr produces a registered write next cycle to mem_we[ioctl_index], with mem_addr = ioctl_addr[ADDR_W-1:0] and mem_din = ioctl_dout.
- A byte is dropped and dn_err is set if ioctl_index ≥ TARGETS or ioctl_addr ≥ 2^ADDR_W.
- ioctl_download falling in LOAD goes to CLEAR with the counter reset, so work RAM is cleared after every download.
- A download starting in CLEAR is deferred: ioctl_wait stays 1 and LOAD is entered after CLEAR completes, bypassing HOLD.
- cpu_wr outside RUN is ignored, with no ack.
- Priority on the shared port: LOAD write > CLEAR write > CPU write. In any one state only one source is legal.
- dn_err is cleared only by reset or by the rising edge of ioctl_download.

## Timing
- Reset values: sys_reset=1, ioctl_wait=1, mem_we=0, mem_addr=0, mem_din=0, cpu_ack=0, dn_err=0.
- All outputs are registered.
- Write latency is 1 cycle from ioctl_wr or cpu_wr to mem_we. Consecutive ioctl_wr cycles are sustained at 1 byte/cycle in LOAD.
- sys_reset is 1 in CLEAR, HOLD and LOAD. It drops on the cycle after the HOLD counter reaches HOLD_CYCLES-1.
- Post-reset sys_reset high time is exactly 2^CLEAR_AW + HOLD_CYCLES + 1 cycles.
- ioctl_wait is 1 only in CLEAR. It drops the cycle after the final clear write.
- Reset asserted mid-LOAD or mid-CLEAR aborts immediately: mem_we=0 next cycle, and the sequence restarts from CLEAR address 0.

## Structure
- Shared package dn_pkg holds:
  - state enum {CLEAR, HOLD, RUN, LOAD};
  - default target index constants (PRG=0, CHR=1, SPR=2, PAL=3, TILE=4, WRAM=5), also used by system for port mapping.
- One natural sub-module: dn_clear_ctr, the clear/hold counter pair with done flags.
- The FSM and write mux stay in dn_sequencer.

## Test plan
- Reset 1 cycle, CLEAR_AW=4, HOLD_CYCLES=16 -> 16 zero writes to mem_we=6'b100000 at addresses 0..15, then sys_reset falls exactly 33 cycles after reset release.
- In RUN, download index 1, bytes 0xA5 at 0x00010 and 0x5A at 0x00011 back-to-back -> mem_we=6'b000010 for two consecutive cycles with matching addr/data; sys_reset=1 from the download edge; after download ends, CLEAR runs again.
- Download byte with index 7 -> no mem_we, dn_err=1. dn_err stays set until the next download start.
- Raise ioctl_download two cycles after reset release -> ioctl_wait=1 until the clear finishes; no write issued before LOAD; the first ioctl_wr after ioctl_wait falls is written.
- In RUN, cpu_wr addr 0x123 data 0x77 -> next cycle mem_we[5]=1 with addr 0x123, din 0x77, cpu_ack=1. The same request in HOLD -> no write, no ack.
- Assert reset mid-LOAD after 3 bytes -> mem_we=0 next cycle, sys_reset=1, clear restarts at address 0.

Source files
------------

// File: rtl/dn_pkg.sv
// Shared types and target-index constants for the download/reset sequencer
// and the system port mapping.
package dn_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        HOLD,
        RUN,
        LOAD
    } dn_state_t;

    localparam int unsigned TGT_PRG  = 0;
    localparam int unsigned TGT_CHR  = 1;
    localparam int unsigned TGT_SPR  = 2;
    localparam int unsigned TGT_PAL  = 3;
    localparam int unsigned TGT_TILE = 4;
    localparam int unsigned TGT_WRAM = 5;

endpackage

// File: rtl/dn_clear_ctr.sv
// Work-RAM clear address counter and post-clear hold counter, each with a
// terminal-count flag for the sequencer FSM.
module dn_clear_ctr #(
    parameter int unsigned CLEAR_AW    = 12,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                clr_en,
    input  logic                clr_restart,
    input  logic                hold_en,
    input  logic                hold_restart,
    output logic [CLEAR_AW-1:0] clr_cnt,
    output logic                clr_done,
    output logic                hold_done
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset || clr_restart) begin
            clr_cnt <= '0;
        end else if (clr_en) begin
            clr_cnt <= clr_cnt + 1'b1;
        end

        if (reset || hold_restart) begin
            hold_cnt <= '0;
        end else if (hold_en) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign clr_done  = (clr_cnt == '1);
    assign hold_done = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/dn_sequencer.sv
// Routes ioctl download bytes to target RAMs, clears work RAM after reset and
// after each download, and holds the system in reset until memory is valid.
module dn_sequencer
    import dn_pkg::*;
#(
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned TARGETS     = 6,
    parameter int unsigned WRAM_TGT    = 5,
    parameter int unsigned CLEAR_AW    = 12,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ioctl_download,
    input  logic               ioctl_wr,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    input  logic [7:0]         ioctl_index,
    output logic               ioctl_wait,
    input  logic               cpu_wr,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [7:0]         cpu_dout,
    output logic               cpu_ack,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [7:0]         mem_din,
    output logic [TARGETS-1:0] mem_we,
    output logic               sys_reset,
    output logic               dn_err
);

    localparam logic [TARGETS-1:0] WRAM_WE = TARGETS'(1) << WRAM_TGT;

    dn_state_t           state;
    logic                dl_prev;
    logic [CLEAR_AW-1:0] clr_cnt;
    logic                clr_done;
    logic                hold_done;
    logic                byte_ok;

    assign byte_ok = (32'(ioctl_index) < TARGETS) && ((ioctl_addr >> ADDR_W) == '0);

    dn_clear_ctr #(
        .CLEAR_AW    (CLEAR_AW),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_clear_ctr (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .clr_en       (state == CLEAR),
        .clr_restart  (state == LOAD && !ioctl_download),
        .hold_en      (state == HOLD),
        .hold_restart (state != HOLD),
        .clr_cnt      (clr_cnt),
        .clr_done     (clr_done),
        .hold_done    (hold_done)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= CLEAR;
            dl_prev    <= 1'b0;
            sys_reset  <= 1'b1;
            ioctl_wait <= 1'b1;
            mem_we     <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            cpu_ack    <= 1'b0;
            dn_err     <= 1'b0;
        end else begin
            dl_prev    <= ioctl_download;
            mem_we     <= '0;
            cpu_ack    <= 1'b0;
            sys_reset  <= 1'b1;
            // Lags the state by one cycle so wait drops after the last clear write.
            ioctl_wait <= (state == CLEAR);

            if (ioctl_download && !dl_prev) begin
                dn_err <= 1'b0;
            end

            unique case (state)
                CLEAR: begin
                    mem_we   <= WRAM_WE;
                    mem_addr <= ADDR_W'(clr_cnt);
                    mem_din  <= '0;
                    if (clr_done) begin
                        state <= ioctl_download ? LOAD : HOLD;
                    end
                end
                HOLD: begin
                    if (ioctl_download) begin
                        state <= LOAD;
                    end else if (hold_done) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (ioctl_download) begin
                        state <= LOAD;
                    end else begin
                        sys_reset <= 1'b0;
                        if (cpu_wr) begin
                            mem_we   <= WRAM_WE;
                            mem_addr <= cpu_addr;
                            mem_din  <= cpu_dout;
                            cpu_ack  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (ioctl_wr) begin
                        if (byte_ok) begin
                            mem_we   <= TARGETS'(1) << ioctl_index;
                            mem_addr <= ioctl_addr[ADDR_W-1:0];
                            mem_din  <= ioctl_dout;
                        end else begin
                            dn_err <= 1'b1;
                        end
                    end
                    if (!ioctl_download) begin
                        state <= CLEAR;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
